// File: rtl/exu_pkg.sv
// ---------------------------------------------------------------------------
// exu_pkg
// Shared definitions for the execute-stage multiply/divide block:
//   - RV32M funct3 encodings
//   - multiply/divide state encoding
//   - quotient value produced by a divide-by-zero
// ---------------------------------------------------------------------------
package exu_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_CORR = 2'd2
  } md_state_e;

  // Wide enough for any XLEN up to 64; users slice the low XLEN bits.
  localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/exu_md_stage_if.sv
// ---------------------------------------------------------------------------
// exu_md_stage_if
// Bundle of the execute-stage input/output signals.
//   master : upstream side (drives i_*, observes o_*)
//   slave  : exu_md_stage side (observes i_*, drives o_*)
// ---------------------------------------------------------------------------
interface exu_md_stage_if #(
  parameter int XLEN    = 32,
  parameter int FWD_SRC = 2
);
  logic                    i_valid;
  logic                    i_is_md;
  logic [2:0]              i_md_op;
  logic [XLEN-1:0]         i_alu_result;
  logic [XLEN-1:0]         i_rs1;
  logic [XLEN-1:0]         i_rs2;
  logic [FWD_SRC*XLEN-1:0] i_fwd_data;
  logic [FWD_SRC-1:0]      i_fwd_sel_rs1;
  logic [FWD_SRC-1:0]      i_fwd_sel_rs2;
  logic                    i_rd_wen;
  logic [4:0]              i_rd_addr;
  logic                    i_pip_flush;
  logic                    o_stall;
  logic                    o_valid;
  logic                    o_rd_wen;
  logic [4:0]              o_rd_addr;
  logic [XLEN-1:0]         o_result;

  modport master (
    output i_valid, i_is_md, i_md_op, i_alu_result, i_rs1, i_rs2, i_fwd_data,
           i_fwd_sel_rs1, i_fwd_sel_rs2, i_rd_wen, i_rd_addr, i_pip_flush,
    input  o_stall, o_valid, o_rd_wen, o_rd_addr, o_result
  );

  modport slave (
    input  i_valid, i_is_md, i_md_op, i_alu_result, i_rs1, i_rs2, i_fwd_data,
           i_fwd_sel_rs1, i_fwd_sel_rs2, i_rd_wen, i_rd_addr, i_pip_flush,
    output o_stall, o_valid, o_rd_wen, o_rd_addr, o_result
  );
endinterface

// File: rtl/exu_md_core.sv
// ---------------------------------------------------------------------------
// exu_md_core
// Iterative RV32M unit: shift-add multiply / restoring divide on operand
// magnitudes, UNROLL bits per cycle, followed by one sign-correction cycle.
// Ports:
//   clk_sys, rst_sys : clock, async active-low reset
//   i_flush          : abandon the operation in flight
//   i_start          : accept i_op/i_a/i_b (only asserted while idle)
//   o_busy           : state != IDLE
//   o_done           : correction cycle; o_result is valid
// UNROLL must divide XLEN.
// ---------------------------------------------------------------------------
module exu_md_core
  import exu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk_sys,
  input  logic            rst_sys,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  localparam int              N        = XLEN / UNROLL;
  localparam int              CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_hi, r_lo, r_opb;
  logic              r_neg_q, r_neg_r;

  logic              w_sa, w_sb, w_div0, w_ovf;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic [XLEN-1:0]   w_hi_nxt, w_lo_nxt;
  logic [XLEN:0]     w_rem_sh, w_diff, w_sum;
  logic [2*XLEN-1:0] w_prod, w_prod_c;
  logic [XLEN-1:0]   w_quot, w_rem;

  // Operand sign interpretation per variant (MULHSU: rs2 unsigned).
  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    case (i_op)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        w_sa = i_a[XLEN-1];
        w_sb = i_b[XLEN-1];
      end
      F3_MULHSU: w_sa = i_a[XLEN-1];
      F3_MULHU, F3_DIVU, F3_REMU: ;
      default: ;
    endcase
  end

  assign w_mag_a = w_sa ? -i_a : i_a;
  assign w_mag_b = w_sb ? -i_b : i_b;
  assign w_div0  = i_op[2] & (i_b == '0);
  assign w_ovf   = i_op[2] & ~i_op[0] & (i_a == XMIN) & (i_b == '1);

  // FSM: state register
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys)     r_state <= ST_IDLE;
    else if (i_flush) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  // FSM: next state; special divides need no iterations
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = (w_div0 | w_ovf) ? ST_CORR : ST_CALC;
      ST_CALC: if (r_cnt == '0) w_state_nxt = ST_CORR;
      ST_CORR: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy = (r_state != ST_IDLE);
    o_done = (r_state == ST_CORR);
  end

  // UNROLL iterations per cycle. Divide: r_hi = partial remainder, r_lo shifts
  // the dividend out and quotient bits in. Multiply: {r_hi,r_lo} is the
  // product with the multiplier consumed from r_lo's LSB.
  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    w_rem_sh = '0;
    w_diff   = '0;
    w_sum    = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (r_op[2]) begin
        w_rem_sh = {w_hi_nxt, w_lo_nxt[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, r_opb};
        w_lo_nxt = {w_lo_nxt[XLEN-2:0], ~w_diff[XLEN]};
        w_hi_nxt = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
      end else begin
        w_sum    = {1'b0, w_hi_nxt} + (w_lo_nxt[0] ? {1'b0, r_opb} : '0);
        w_lo_nxt = {w_sum[0], w_lo_nxt[XLEN-1:1]};
        w_hi_nxt = w_sum[XLEN:1];
      end
    end
  end

  // Datapath registers. Special divides preload their final answer so the
  // correction stage handles them unchanged (both negate flags cleared).
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opb   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_start && r_state == ST_IDLE) begin
      r_cnt <= CNT_LAST;
      r_op  <= i_op;
      r_opb <= i_op[2] ? w_mag_b : w_mag_a;
      if (w_div0) begin
        r_hi    <= i_a;
        r_lo    <= DIV0_QUOT[XLEN-1:0];
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else if (w_ovf) begin
        r_hi    <= '0;
        r_lo    <= XMIN;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else begin
        r_hi    <= '0;
        r_lo    <= i_op[2] ? w_mag_a : w_mag_b;
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
      end
    end else if (r_state == ST_CALC) begin
      r_cnt <= r_cnt - 1'b1;
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
    end
  end

  // Sign correction and half/quotient/remainder selection
  assign w_prod   = {r_hi, r_lo};
  assign w_prod_c = r_neg_q ? -w_prod : w_prod;
  assign w_quot   = r_neg_q ? -r_lo : r_lo;
  assign w_rem    = r_neg_r ? -r_hi : r_hi;

  always_comb begin
    case (r_op)
      F3_MUL:                       o_result = w_prod_c[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: o_result = w_prod_c[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              o_result = w_quot;
      default:                      o_result = w_rem;
    endcase
  end

endmodule

// File: rtl/exu_md_stage.sv
// ---------------------------------------------------------------------------
// exu_md_stage
// Execute-stage output register with an iterative RV32M unit.
// Ports:
//   clk_sys : system clock
//   rst_sys : asynchronous active-low reset
//   bus     : exu_md_stage_if.slave
//             i_* instruction, operands, forwarding, flush
//             o_stall (busy), o_valid pulse, o_rd_wen/o_rd_addr, o_result
// Single-cycle ALU results appear one cycle after accept; M ops stall the
// stage until the core finishes. Flush discards whatever is in flight.
// ---------------------------------------------------------------------------
module exu_md_stage
  import exu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int FWD_SRC = 2,
  parameter int UNROLL  = 1
) (
  input  logic          clk_sys,
  input  logic          rst_sys,
  exu_md_stage_if.slave bus
);
  logic [XLEN-1:0] w_fwd1, w_fwd2, w_rs1, w_rs2, w_md_result;
  logic            w_busy, w_done, w_accept, w_start;

  logic            r_valid, r_rd_wen, r_md_rd_wen;
  logic [4:0]      r_rd_addr, r_md_rd_addr;
  logic [XLEN-1:0] r_result;

  // One-hot forwarding; overlapping selects OR their sources together.
  always_comb begin
    w_fwd1 = '0;
    w_fwd2 = '0;
    for (int k = 0; k < FWD_SRC; k++) begin
      if (bus.i_fwd_sel_rs1[k]) w_fwd1 |= bus.i_fwd_data[k*XLEN +: XLEN];
      if (bus.i_fwd_sel_rs2[k]) w_fwd2 |= bus.i_fwd_data[k*XLEN +: XLEN];
    end
    w_rs1 = (|bus.i_fwd_sel_rs1) ? w_fwd1 : bus.i_rs1;
    w_rs2 = (|bus.i_fwd_sel_rs2) ? w_fwd2 : bus.i_rs2;
  end

  assign w_accept = bus.i_valid & ~w_busy & ~bus.i_pip_flush;
  assign w_start  = w_accept & bus.i_is_md;

  exu_md_core #(
    .XLEN   (XLEN),
    .UNROLL (UNROLL)
  ) u_core (
    .clk_sys  (clk_sys),
    .rst_sys  (rst_sys),
    .i_flush  (bus.i_pip_flush),
    .i_start  (w_start),
    .i_op     (bus.i_md_op),
    .i_a      (w_rs1),
    .i_b      (w_rs2),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_result (w_md_result)
  );

  // Destination of the M op in flight
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      r_md_rd_wen  <= 1'b0;
      r_md_rd_addr <= '0;
    end else if (w_start) begin
      r_md_rd_wen  <= bus.i_rd_wen & (bus.i_rd_addr != 5'd0);
      r_md_rd_addr <= bus.i_rd_addr;
    end
  end

  // Output registers; accept of a non-M op and core completion never overlap
  // because accept requires the core to be idle.
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      r_valid   <= 1'b0;
      r_rd_wen  <= 1'b0;
      r_rd_addr <= '0;
      r_result  <= '0;
    end else if (bus.i_pip_flush) begin
      r_valid  <= 1'b0;
      r_rd_wen <= 1'b0;
    end else if (w_accept && !bus.i_is_md) begin
      r_valid   <= 1'b1;
      r_rd_wen  <= bus.i_rd_wen & (bus.i_rd_addr != 5'd0);
      r_rd_addr <= bus.i_rd_addr;
      r_result  <= bus.i_alu_result;
    end else if (w_done) begin
      r_valid   <= 1'b1;
      r_rd_wen  <= r_md_rd_wen;
      r_rd_addr <= r_md_rd_addr;
      r_result  <= w_md_result;
    end else begin
      r_valid  <= 1'b0;
      r_rd_wen <= 1'b0;
    end
  end

  assign bus.o_stall   = w_busy;
  assign bus.o_valid   = r_valid;
  assign bus.o_rd_wen  = r_rd_wen;
  assign bus.o_rd_addr = r_rd_addr;
  assign bus.o_result  = r_result;

endmodule
